// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- registered 32-bit integer ALU for the MIPS-style datapath.
//
// The operation is computed combinationally from the current inputs and
// captured on the rising clock edge. Latency is one clock. A new operation
// may be issued every cycle.
//
// Ports:
//   clk     in   1   rising-edge clock
//   rst     in   1   asynchronous active-high reset
//   x       in  32   operand A (rs)
//   y       in  32   operand B (rt / immediate), also the shift source
//   shamt   in   5   shift amount for SRL/SLL
//   ALUout  in   4   operation code from ALU control
//   result  out 32   registered operation result
//   ZeroF   out  1   registered flag, 1 when result is 0
//   OvF     out  1   registered signed-overflow flag (only with ALU_OVF_EN)
//
// Configuration macro: ALU_OVF_EN
//   Defined   -> OvF port and signed-overflow detection for ADD/SUB.
//   Undefined -> no OvF port, no overflow logic.
// ---------------------------------------------------------------------------
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [4:0]  shamt,
  input  logic [3:0]  ALUout,
  output logic [31:0] result,
`ifdef ALU_OVF_EN
  output logic        ZeroF,
  output logic        OvF
`else
  output logic        ZeroF
`endif
);

  typedef enum logic [3:0] {
    OP_AND  = 4'h0,
    OP_OR   = 4'h1,
    OP_ADD  = 4'h2,
    OP_XOR  = 4'h5,
    OP_SUB  = 4'h6,
    OP_SLT  = 4'h7,
    OP_SRL  = 4'h8,
    OP_ADDU = 4'hA,
    OP_NOR  = 4'hC,
    OP_SUBU = 4'hE,
    OP_SLL  = 4'hF
  } aluop_t;

  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] nextresult;
  logic        nextzero;

  assign sum  = x + y;
  assign diff = x - y;

  // Operation select. Shifts read only y and shamt, and only shifts read
  // shamt, so an X on an unused operand never reaches the result. SLT uses a
  // true signed comparison so it stays correct when x - y overflows.
  always_comb begin
    nextresult = 32'd0;
    case (ALUout)
      OP_AND:  nextresult = x & y;
      OP_OR:   nextresult = x | y;
      OP_ADD:  nextresult = sum;
      OP_ADDU: nextresult = sum;
      OP_SUB:  nextresult = diff;
      OP_SUBU: nextresult = diff;
      OP_XOR:  nextresult = x ^ y;
      OP_NOR:  nextresult = ~(x | y);
      OP_SLT:  nextresult = {31'd0, ($signed(x) < $signed(y))};
      OP_SRL:  nextresult = y >> shamt;
      OP_SLL:  nextresult = y << shamt;
      default: nextresult = 32'd0;
    endcase
  end

  assign nextzero = (nextresult == 32'd0);

`ifdef ALU_OVF_EN
  logic nextovf;

  // Signed overflow: ADD overflows when both operands share a sign the sum
  // does not; SUB overflows when the operands differ in sign and the
  // difference's sign differs from x. Unsigned variants never flag.
  always_comb begin
    nextovf = 1'b0;
    case (ALUout)
      OP_ADD:  nextovf = (x[31] == y[31]) && (sum[31] != x[31]);
      OP_SUB:  nextovf = (x[31] != y[31]) && (diff[31] != x[31]);
      default: nextovf = 1'b0;
    endcase
  end

  // Overflow flag register, captured alongside the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      OvF <= 1'b0;
    end else begin
      OvF <= nextovf;
    end
  end
`endif

  // Output registers. Reset clears both outputs, ZeroF included, even
  // though the cleared result is zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= 32'd0;
      ZeroF  <= 1'b0;
    end else begin
      result <= nextresult;
      ZeroF  <= nextzero;
    end
  end

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu. Directed vectors are followed by
// randomized operations, all checked against a behavioural model built from
// plain wide arithmetic.
// ---------------------------------------------------------------------------
module tb_alu;

  logic        clk;
  logic        rst;
  logic [31:0] x;
  logic [31:0] y;
  logic [4:0]  shamt;
  logic [3:0]  ALUout;
  logic [31:0] result;
  logic        ZeroF;
  logic        ovf;

  int total;
  int bad;

  alu dut (
    .clk    (clk),
    .rst    (rst),
    .x      (x),
    .y      (y),
    .shamt  (shamt),
    .ALUout (ALUout),
    .result (result),
`ifdef ALU_OVF_EN
    .ZeroF  (ZeroF),
    .OvF    (ovf)
`else
    .ZeroF  (ZeroF)
`endif
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural result: evaluate with 64-bit integers and keep the low word.
  function automatic logic [31:0] modelResult(input logic [3:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [4:0] sh);
    longint sa;
    longint sb;
    longint wide;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    wide = 0;
    case (op)
      4'h0: wide = longint'(a & b);
      4'h1: wide = longint'(a | b);
      4'h2, 4'hA: wide = sa + sb;
      4'h6, 4'hE: wide = sa - sb;
      4'h5: wide = longint'(a ^ b);
      4'hC: wide = longint'(~(a | b));
      4'h7: wide = (sa < sb) ? 1 : 0;
      4'h8: wide = longint'(b) / (longint'(1) << sh);
      4'hF: wide = longint'(b) * (longint'(1) << sh);
      default: wide = 0;
    endcase
    return wide[31:0];
  endfunction

  // Behavioural overflow: true signed result outside the 32-bit range.
  function automatic logic modelOvf(input logic [3:0] op,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
    longint sa;
    longint sb;
    longint wide;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 4'h2)      wide = sa + sb;
    else if (op == 4'h6) wide = sa - sb;
    else                 return 1'b0;
    return (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
  endfunction

  // Drive one operation away from the clock edge, then let it be captured
  // and step just past the edge for sampling.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] sh);
    @(negedge clk);
    ALUout = op;
    x      = a;
    y      = b;
    shamt  = sh;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] expRes,
                             input logic expZero, input logic expOvf);
    total++;
    assert (result === expRes) else begin
      bad++;
      $error("[TB] FAIL %s result got=%h exp=%h", tag, result, expRes);
    end
    total++;
    assert (ZeroF === expZero) else begin
      bad++;
      $error("[TB] FAIL %s ZeroF got=%b exp=%b", tag, ZeroF, expZero);
    end
`ifdef ALU_OVF_EN
    total++;
    assert (ovf === expOvf) else begin
      bad++;
      $error("[TB] FAIL %s OvF got=%b exp=%b", tag, ovf, expOvf);
    end
`else
    if (expOvf === 1'bx) $display("[TB] note: unexpected X in overflow model");
`endif
  endtask

  task automatic runOp(input string tag, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    logic [31:0] r;
    r = modelResult(op, a, b, sh);
    applyStimulus(op, a, b, sh);
    checkOutput(tag, r, (r == 32'd0), modelOvf(op, a, b));
  endtask

  logic [3:0] opList [16];
  logic [3:0] rop;
  logic [31:0] ra;
  logic [31:0] rb;
  logic [4:0] rsh;
  logic [31:0] r;

  initial begin
    total = 0;
    bad   = 0;
    opList = '{4'h0, 4'h1, 4'h2, 4'hA, 4'h6, 4'hE, 4'h5, 4'hC,
               4'h7, 4'h8, 4'hF, 4'h3, 4'h4, 4'h9, 4'hB, 4'hD};
    rst    = 1'b1;
    x      = 32'd0;
    y      = 32'd0;
    shamt  = 5'd0;
    ALUout = 4'h1;
    $display("[TB] start");

    // Reset state: outputs cleared, ZeroF low despite zero result.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors.
    runOp("and",   4'h0, 32'hFFFFFFFF, 32'h00000001, 5'd0);
    runOp("or",    4'h1, 32'hFFFFFFFF, 32'h00000001, 5'd0);
    runOp("add",   4'h2, 32'hFFFFFFFC, 32'h00000003, 5'd0);
    runOp("addu",  4'hA, 32'd1, 32'd1, 5'd0);
    runOp("sub",   4'h6, 32'hFFFFFFFC, 32'h00000008, 5'd0);
    runOp("subu",  4'hE, 32'd4, 32'd2, 5'd0);
    runOp("xor",   4'h5, 32'd0, 32'd1, 5'd0);
    runOp("nor",   4'hC, 32'hFFFFFFFF, 32'd1, 5'd0);
    runOp("slt0",  4'h7, 32'd8, 32'd1, 5'd0);
    runOp("sltov", 4'h7, 32'h80000000, 32'd1, 5'd0);
    runOp("sltpn", 4'h7, 32'h7FFFFFFF, 32'hFFFFFFFF, 5'd0);
    runOp("srlx",  4'h8, 32'hxxxxxxxx, 32'd8, 5'd2);
    runOp("sll",   4'hF, 32'hxxxxxxxx, 32'd2, 5'd2);
    runOp("sll31", 4'hF, 32'd0, 32'd1, 5'd31);
    runOp("andsx", 4'h0, 32'hF0F0F0F0, 32'hFF00FF00, 5'bxxxxx);
    runOp("ovadd", 4'h2, 32'h7FFFFFFF, 32'd1, 5'd0);
    runOp("ovaddu",4'hA, 32'h7FFFFFFF, 32'd1, 5'd0);
    runOp("ovsub", 4'h6, 32'h80000000, 32'd1, 5'd0);
    runOp("unused",4'h3, 32'h12345678, 32'h9ABCDEF0, 5'd7);

    // Asynchronous reset mid-cycle while the result is nonzero.
    runOp("prerst", 4'h1, 32'h00FF0000, 32'h0000000F, 5'd0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncrst", 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("rsthold", 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    runOp("postrst", 4'h2, 32'd5, 32'd6, 5'd0);

    // Randomized back-to-back operations.
    for (int i = 0; i < 300; i++) begin
      rop = opList[$urandom_range(0, 15)];
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      if ($urandom_range(0, 5) == 0) ra = {ra[31], 31'h7FFFFFF0 | ra[3:0]};
      rsh = 5'($urandom_range(0, 31));
      r   = modelResult(rop, ra, rb, rsh);
      applyStimulus(rop, ra, rb, rsh);
      checkOutput($sformatf("rand%0d_op%h", i, rop), r, (r == 32'd0),
                  modelOvf(rop, ra, rb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Registered 32-bit integer ALU for the single-cycle/pipelined MIPS-style datapath. Takes two operands, a 5-bit shift amount and a 4-bit operation code from ALU control. Computes logic, add/subtract, set-less-than and logical shifts. Result and zero flag are captured on the clock edge for the next stage.

## Interface
Parameters: none (datapath width fixed at 32).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- x  input  32  operand A (rs)
- y  input  32  operand B (rt / immediate); shift source for shifts
- shamt  input  5  shift amount for SRL/SLL
- ALUout  input  4  operation code from ALU control
- result  output  32  registered operation result
- ZeroF  output  1  registered flag, 1 when the registered result equals 0
- OvF  output  1  registered signed-overflow flag; present only with ALU_OVF_EN

## Operation
Op codes, all 32-bit with wrap-around:
- 0x0 AND: x & y
- 0x1 OR: x | y
- 0x2 ADD (signed): x + y
- 0xA ADDU (unsigned): x + y, never flags overflow
- 0x6 SUB (signed): x − y
- 0xE SUBU (unsigned): x − y, never flags overflow
- 0x5 XOR: x ^ y
- 0xC NOR: ~(x | y)
- 0x7 SLT: 32'd1 if $signed(x) < $signed(y), else 0
- 0x8 SRL: y >> shamt, zero fill
- 0xF SLL: y << shamt, zero fill

Rules:
- x is ignored for SRL/SLL; X on x must not propagate into the result.
- shamt is ignored for all non-shift ops; X on shamt must not propagate into the result.
- Unused codes (0x3, 0x4, 0x9, 0xB, 0xD) produce result 0 and ZeroF 1.
- SLT compares the true signed order of x and y, not just the sign of the difference, so it is correct when x − y overflows.
- ZeroF = (next result == 0), computed from the same value that is registered into result.

## Timing
- Combinational compute feeds the output registers; latency is exactly 1 clock.
- Inputs sampled at rising clk edge N appear on result/ZeroF(/OvF) after edge N and hold until edge N+1.
- No handshake: a new operation may be issued every cycle; back-to-back ops are fully pipelined.
- On rst assertion (asynchronous, mid-cycle allowed): result = 0, ZeroF = 0, OvF = 0 immediately.
- Outputs hold these values while rst is high.
- First capture happens on the first rising clk after rst deasserts.

## Configuration
- Macro ALU_OVF_EN.
- Defined:
  - Port OvF exists.
  - For op 0x2, OvF = operand signs equal and result sign differs.
  - For op 0x6, OvF = operand signs differ and result sign differs from x.
  - OvF is 0 for all other ops.
  - OvF is registered alongside result; result still wraps.
- Undefined: no OvF port and no overflow logic. All other behaviour is identical.

## Test plan
- AND x=FFFFFFFF, y=00000001, op 0 -> result 00000001, ZeroF 0. OR with the same operands, op 1 -> FFFFFFFF.
- ADD x=FFFFFFFC, y=3, op 2 -> FFFFFFFF. ADDU 1+1, op A -> 2. SUB x=FFFFFFFC, y=8, op 6 -> FFFFFFF4. SUBU 4−2, op E -> 2. Each result appears one clk after the inputs.
- XOR 0^1, op 5 -> 1. NOR FFFFFFFF|1, op C -> 0 with ZeroF 1. SLT 8<1, op 7 -> 0. SLT x=80000000, y=1 -> 1 (overflowing difference).
- SRL y=8, shamt=2, x=X, op 8 -> 2. SLL y=2, shamt=2, op F -> 8. SLL y=1, shamt=31 -> 80000000. Result free of X.
- Assert rst mid-cycle while the result is nonzero -> outputs go to 0/0/0 immediately without a clk edge. Unused op 3 -> result 0, ZeroF 1.
- With ALU_OVF_EN: ADD 7FFFFFFF+1 -> 80000000, OvF 1. ADDU with the same operands -> OvF 0. SUB 80000000−1 -> OvF 1.
